mem_access_unit: RTL and testbench

- Memory-stage data-memory access controller, sitting between the EX/MEM pipeline register outputs and the MEM/WB pipeline register inputs.
- Converts the M-stage load/store control into a registered request/ready transaction on a variable-latency data-memory bus.
- Formats byte, halfword and word loads and stores, and stalls the pipeline until the access completes.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage data-memory access controller: turns M-stage load/store control into a
// registered req/ready bus transaction, formats sub-word data and stalls until completion.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        LoadUnsignedM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] MemReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } stateE;

  typedef enum logic [1:0] {
    SIZE_WORD     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_BYTE     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } memSizeE;

  localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

  stateE       state;
  stateE       nextState;

  logic        access;
  logic        isByte;
  logic        isHalf;
  logic        aligned;
  logic        startAccess;
  logic [31:0] storeData;
  logic [3:0]  storeBe;

  logic [15:0] busyCount;
  logic        timeoutHit;

  // Attributes of the in-flight access, needed to format the returning load data.
  logic [1:0]  laneQ;
  memSizeE     sizeQ;
  logic        unsignedQ;
  logic [7:0]  byteField;
  logic [15:0] halfField;
  logic [31:0] loadData;

  // ---------------------------------------------------------------------------
  // Request decode and alignment
  // ---------------------------------------------------------------------------
  always_comb begin
    access      = MemReadM | MemWriteM;
    isByte      = (memSizeE'(MemSizeM) == SIZE_BYTE);
    isHalf      = (memSizeE'(MemSizeM) == SIZE_HALF);
    aligned     = isByte
                | (isHalf & ~ALUResultM[0])
                | (~isByte & ~isHalf & (ALUResultM[1:0] == 2'b00));
    startAccess = access & aligned;
  end

  // Store lane replication and byte enables (little-endian).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    storeData = WriteDataM;
    storeBe   = 4'b1111;
    if (isByte) begin
      storeData = {4{WriteDataM[7:0]}};
      storeBe   = 4'b0001 << ALUResultM[1:0];
    end else if (isHalf) begin
      storeData = {2{WriteDataM[15:0]}};
      storeBe   = ALUResultM[1] ? 4'b1100 : 4'b0011;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data selection and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    byteField = dmem_rdata[7:0];
    case (laneQ)
      2'd0:    byteField = dmem_rdata[7:0];
      2'd1:    byteField = dmem_rdata[15:8];
      2'd2:    byteField = dmem_rdata[23:16];
      default: byteField = dmem_rdata[31:24];
    endcase
    halfField = laneQ[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    loadData = dmem_rdata;
    case (sizeQ)
      SIZE_BYTE: loadData = unsignedQ ? {24'd0, byteField}
                                      : {{24{byteField[7]}}, byteField};
      SIZE_HALF: loadData = unsignedQ ? {16'd0, halfField}
                                      : {{16{halfField[15]}}, halfField};
      default:   loadData = dmem_rdata;
    endcase
  end

  assign timeoutHit = (busyCount == LastCount);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    StallM    = 1'b0;
    case (state)
      IDLE: begin
        StallM = startAccess;
        if (startAccess) nextState = BUSY;
      end
      BUSY: begin
        StallM = 1'b1;
        if (dmem_ready || timeoutHit) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus registers, result register, status pulses and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      MemReadDataM <= 32'd0;
      MisalignM    <= 1'b0;
      BusErrM      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      dmem_be      <= 4'd0;
      busyCount    <= 16'd0;
      laneQ        <= 2'd0;
      sizeQ        <= SIZE_WORD;
      unsignedQ    <= 1'b0;
    end else begin
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      case (state)
        IDLE: begin
          if (startAccess) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_wdata <= MemWriteM ? storeData : 32'd0;
            dmem_be    <= MemWriteM ? storeBe : 4'b1111;
            laneQ      <= ALUResultM[1:0];
            sizeQ      <= memSizeE'(MemSizeM);
            unsignedQ  <= LoadUnsignedM;
            busyCount  <= 16'd0;
          end else if (access) begin
            MisalignM    <= 1'b1;
            MemReadDataM <= 32'd0;
          end
        end
        BUSY: begin
          busyCount <= busyCount + 16'd1;
          if (dmem_ready) begin
            dmem_req     <= 1'b0;
            MemReadDataM <= dmem_we ? 32'd0 : loadData;
          end else if (timeoutHit) begin
            dmem_req     <= 1'b0;
            BusErrM      <= 1'b1;
            MemReadDataM <= 32'd0;
          end
        end
        DONE:    busyCount <= 16'd0;
        default: busyCount <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout and
// mid-transaction reset, with hand-computed expected values.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        MemReadM, MemWriteM, LoadUnsignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic [31:0] MemReadDataM, dmem_addr, dmem_wdata;
  logic        StallM, MisalignM, BusErrM, dmem_req, dmem_we;
  logic [3:0]  dmem_be;

  // Short-timeout instance whose bus never answers.
  logic        readyTo = 1'b0;
  logic [31:0] toReadData, toAddr, toWdata;
  logic        toStall, toMisalign, toBusErr, toReq, toWe;
  logic [3:0]  toBe;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        stallIdle;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stallBusy;
    logic [31:0] rdOut;
    logic        stallDone;
    logic        reqDone;
  } snapT;

  mem_access_unit u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .LoadUnsignedM(LoadUnsignedM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .MemReadDataM(MemReadDataM), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) u_dutTo (
    .Clk(Clk), .Reset_n(Reset_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .LoadUnsignedM(LoadUnsignedM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .MemReadDataM(toReadData), .StallM(toStall),
    .MisalignM(toMisalign), .BusErrM(toBusErr), .dmem_req(toReq), .dmem_we(toWe),
    .dmem_addr(toAddr), .dmem_wdata(toWdata), .dmem_be(toBe),
    .dmem_ready(readyTo), .dmem_rdata(dmem_rdata)
  );

  always #5 Clk = ~Clk;

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    MemReadM      = rd;
    MemWriteM     = wr;
    MemSizeM      = size;
    LoadUnsignedM = uns;
    ALUResultM    = addr;
    WriteDataM    = wd;
  endtask

  task automatic clearInputs();
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  // One access with dmem_ready in the first BUSY cycle; leaves the DUT in DONE.
  task automatic runAccess(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, output snapT s);
    cyc();
    issue(rd, wr, size, uns, addr, wd);
    settle();
    s.stallIdle = StallM;
    cyc();
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    settle();
    s.req = dmem_req; s.we = dmem_we; s.addr = dmem_addr;
    s.wdata = dmem_wdata; s.be = dmem_be; s.stallBusy = StallM;
    cyc();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    clearInputs();
    settle();
    s.rdOut = MemReadDataM; s.stallDone = StallM; s.reqDone = dmem_req;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    clearInputs();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    repeat (2) cyc();
    settle();
    vectors++; if ({dmem_req, dmem_we, dmem_be, MisalignM, BusErrM, StallM} !== 9'd0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 0", {dmem_req, dmem_we, dmem_be, MisalignM, BusErrM, StallM}); end
    vectors++; if (dmem_addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", dmem_addr); end
    vectors++; if (dmem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", dmem_wdata); end
    vectors++; if (MemReadDataM !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", MemReadDataM); end
    Reset_n = 1'b1;
  endtask

  task automatic test_word_load();
    snapT s;
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'd0, 32'h89ABCDEF, s);
    vectors++; if (s.stallIdle !== 1'b1) begin miscompares++; $display("FAIL lw_stall_idle: got %b want 1", s.stallIdle); end
    vectors++; if (s.stallBusy !== 1'b1) begin miscompares++; $display("FAIL lw_stall_busy: got %b want 1", s.stallBusy); end
    vectors++; if (s.req !== 1'b1) begin miscompares++; $display("FAIL lw_req: got %b want 1", s.req); end
    vectors++; if (s.we !== 1'b0) begin miscompares++; $display("FAIL lw_we: got %b want 0", s.we); end
    vectors++; if (s.addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr: got %h want 00000100", s.addr); end
    vectors++; if (s.be !== 4'b1111) begin miscompares++; $display("FAIL lw_be: got %b want 1111", s.be); end
    vectors++; if (s.rdOut !== 32'h89ABCDEF) begin miscompares++; $display("FAIL lw_data: got %h want 89abcdef", s.rdOut); end
    vectors++; if ({s.stallDone, s.reqDone} !== 2'b00) begin miscompares++; $display("FAIL lw_done_release: got %b want 00", {s.stallDone, s.reqDone}); end
  endtask

  task automatic test_sub_word_loads();
    snapT s;
    runAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'd0, 32'h80FF0011, s);
    vectors++; if (s.rdOut !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_signed: got %h want ffffff80", s.rdOut); end
    runAccess(1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'd0, 32'h80FF0011, s);
    vectors++; if (s.rdOut !== 32'h00000080) begin miscompares++; $display("FAIL lbu: got %h want 00000080", s.rdOut); end
    runAccess(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 32'h80FF0011, s);
    vectors++; if (s.rdOut !== 32'hFFFF80FF) begin miscompares++; $display("FAIL lh_signed: got %h want ffff80ff", s.rdOut); end
    runAccess(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'd0, 32'h80FF8011, s);
    vectors++; if (s.rdOut !== 32'h00008011) begin miscompares++; $display("FAIL lhu_low: got %h want 00008011", s.rdOut); end
    runAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 32'h80FF7F11, s);
    vectors++; if (s.rdOut !== 32'h0000007F) begin miscompares++; $display("FAIL lb_lane1: got %h want 0000007f", s.rdOut); end
  endtask

  task automatic test_stores();
    snapT s;
    runAccess(1'b0, 1'b1, 2'b10, 1'b0, 32'h201, 32'h000000A5, 32'd0, s);
    vectors++; if (s.wdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL sb_wdata: got %h want a5a5a5a5", s.wdata); end
    vectors++; if (s.be !== 4'b0010) begin miscompares++; $display("FAIL sb_be: got %b want 0010", s.be); end
    vectors++; if (s.addr !== 32'h200) begin miscompares++; $display("FAIL sb_addr: got %h want 00000200", s.addr); end
    vectors++; if ({s.req, s.we} !== 2'b11) begin miscompares++; $display("FAIL sb_req_we: got %b want 11", {s.req, s.we}); end
    runAccess(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 32'd0, s);
    vectors++; if (s.wdata !== 32'h12341234) begin miscompares++; $display("FAIL sh_wdata: got %h want 12341234", s.wdata); end
    vectors++; if (s.be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b want 1100", s.be); end
    runAccess(1'b0, 1'b1, 2'b11, 1'b0, 32'h204, 32'hDEADBEEF, 32'd0, s);
    vectors++; if ({s.wdata, s.be} !== {32'hDEADBEEF, 4'b1111}) begin
      miscompares++; $display("FAIL sw_size3: got %h/%b want deadbeef/1111", s.wdata, s.be); end
    // Read and write together is a store and returns zero load data.
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h208, 32'd0, 32'h55AA55AA, s);
    runAccess(1'b1, 1'b1, 2'b10, 1'b0, 32'h203, 32'h000000C3, 32'h11111111, s);
    vectors++; if ({s.we, s.be, s.wdata} !== {1'b1, 4'b1000, 32'hC3C3C3C3}) begin
      miscompares++; $display("FAIL rw_is_store: got %b/%b/%h want 1/1000/c3c3c3c3", s.we, s.be, s.wdata); end
    vectors++; if (s.rdOut !== 32'd0) begin miscompares++; $display("FAIL rw_rdata: got %h want 0", s.rdOut); end
  endtask

  task automatic test_misalign();
    snapT s;
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h108, 32'd0, 32'h12345678, s);
    cyc();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'd0);
    settle();
    vectors++; if ({StallM, dmem_req} !== 2'b00) begin miscompares++; $display("FAIL mis_lw_stall: got %b want 00", {StallM, dmem_req}); end
    cyc();
    clearInputs();
    settle();
    vectors++; if (MisalignM !== 1'b1) begin miscompares++; $display("FAIL mis_lw_pulse: got %b want 1", MisalignM); end
    vectors++; if (MemReadDataM !== 32'd0) begin miscompares++; $display("FAIL mis_lw_rdata: got %h want 0", MemReadDataM); end
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL mis_lw_req: got %b want 0", dmem_req); end
    cyc();
    settle();
    vectors++; if (MisalignM !== 1'b0) begin miscompares++; $display("FAIL mis_pulse_width: got %b want 0", MisalignM); end
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'h0000FFFF);
    settle();
    vectors++; if (StallM !== 1'b0) begin miscompares++; $display("FAIL mis_sh_stall: got %b want 0", StallM); end
    cyc();
    clearInputs();
    settle();
    vectors++; if ({MisalignM, dmem_req, dmem_we} !== 3'b100) begin
      miscompares++; $display("FAIL mis_sh_suppress: got %b want 100", {MisalignM, dmem_req, dmem_we}); end
  endtask

  task automatic test_timeout();
    int reqCycles = 0;
    clearInputs();
    repeat (8) cyc();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h300, 32'd0);
    settle();
    vectors++; if (toStall !== 1'b1) begin miscompares++; $display("FAIL to_stall_idle: got %b want 1", toStall); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      settle();
      if (toReq) reqCycles++;
      else break;
    end
    vectors++; if (reqCycles !== 4) begin miscompares++; $display("FAIL to_req_cycles: got %0d want 4", reqCycles); end
    vectors++; if (toBusErr !== 1'b1) begin miscompares++; $display("FAIL to_buserr: got %b want 1", toBusErr); end
    vectors++; if ({toStall, toReadData} !== 33'd0) begin
      miscompares++; $display("FAIL to_done: got stall %b data %h want 0/0", toStall, toReadData); end
    clearInputs();
    cyc();
    settle();
    vectors++; if ({toBusErr, toReq, toStall} !== 3'b000) begin
      miscompares++; $display("FAIL to_after: got %b want 000", {toBusErr, toReq, toStall}); end
    // The main instance is still waiting on the silent bus; resynchronise it.
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    snapT s;
    cyc();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h400, 32'd0);
    repeat (3) cyc();
    settle();
    vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy: got %b want 1", dmem_req); end
    cyc();
    Reset_n = 1'b0;
    clearInputs();
    cyc();
    Reset_n = 1'b1;
    settle();
    vectors++; if ({dmem_req, dmem_we, dmem_be, StallM, MisalignM, BusErrM} !== 9'd0) begin
      miscompares++; $display("FAIL rst_mid_ctrl: got %b want 0", {dmem_req, dmem_we, dmem_be, StallM, MisalignM, BusErrM}); end
    vectors++; if ({dmem_addr, dmem_wdata, MemReadDataM} !== 96'd0) begin
      miscompares++; $display("FAIL rst_mid_data: got %h %h %h want 0", dmem_addr, dmem_wdata, MemReadDataM); end
    cyc();
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEBABE;
    cyc();
    settle();
    vectors++; if ({MemReadDataM, dmem_req, StallM} !== 34'd0) begin
      miscompares++; $display("FAIL rst_late_ready: got %h/%b/%b want 0", MemReadDataM, dmem_req, StallM); end
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h404, 32'd0, 32'h0BADF00D, s);
    vectors++; if ({s.stallIdle, s.req, s.addr} !== {1'b1, 1'b1, 32'h404}) begin
      miscompares++; $display("FAIL rst_next_req: got %b/%b/%h want 1/1/00000404", s.stallIdle, s.req, s.addr); end
    vectors++; if (s.rdOut !== 32'h0BADF00D) begin miscompares++; $display("FAIL rst_next_data: got %h want 0badf00d", s.rdOut); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_sub_word_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
